// File: rtl/mul_div_unit_pkg.sv
// Shared opcode, state and sizing definitions for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int MDU_CWIDTH = 3;

  typedef enum logic [MDU_CWIDTH-1:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_DIV   = 3'd2,
    MDU_OP_DIVU  = 3'd3,
    MDU_OP_MTHI  = 3'd4,
    MDU_OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_S_IDLE = 2'd0,
    MDU_S_CALC = 2'd1,
    MDU_S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of a W-bit value.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] iVal,
  input  logic         iNeg,
  output logic [W-1:0] oVal
);

  // negate when requested, otherwise pass through
  always_comb begin
    if (iNeg) begin
      oVal = ~iVal + {{(W-1){1'b0}}, 1'b1};
    end else begin
      oVal = iVal;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q, op_d, op_in;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic             signed_in, div_in, is_div_q, is_signed_q;
  logic [WIDTH-1:0] mag_a, mag_b, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix, mul_next, div_next;
  logic [WIDTH:0]   mul_sum, div_trial;

  assign op_in       = mdu_op_e'(iOp);
  assign signed_in   = (op_in == MDU_OP_MULT) || (op_in == MDU_OP_DIV);
  assign div_in      = (op_in == MDU_OP_DIV) || (op_in == MDU_OP_DIVU);
  assign is_div_q    = (op_q == MDU_OP_DIV) || (op_q == MDU_OP_DIVU);
  assign is_signed_q = (op_q == MDU_OP_MULT) || (op_q == MDU_OP_DIV);

  mdu_sign_fix #(.W(WIDTH)) u_mag_a (.iVal(iA), .iNeg(signed_in & iA[WIDTH-1]), .oVal(mag_a));
  mdu_sign_fix #(.W(WIDTH)) u_mag_b (.iVal(iB), .iNeg(signed_in & iB[WIDTH-1]), .oVal(mag_b));

  mdu_sign_fix #(.W(2*WIDTH)) u_prod (.iVal(acc_q), .iNeg(is_signed_q & (sa_q ^ sb_q)), .oVal(prod_fix));
  mdu_sign_fix #(.W(WIDTH)) u_quot (.iVal(acc_q[WIDTH-1:0]), .iNeg(is_signed_q & (sa_q ^ sb_q)), .oVal(quot_fix));
  mdu_sign_fix #(.W(WIDTH)) u_rem (.iVal(acc_q[2*WIDTH-1:WIDTH]), .iNeg(is_signed_q & sa_q), .oVal(rem_fix));

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_orig_d = a_orig_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      MDU_S_IDLE: begin
        if (iStart) begin
          case (op_in)
            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
              op_d     = op_in;
              sa_d     = signed_in & iA[WIDTH-1];
              sb_d     = signed_in & iB[WIDTH-1];
              a_orig_d = iA;
              opnd_d   = div_in ? mag_b : mag_a;
              acc_d    = {{WIDTH{1'b0}}, (div_in ? mag_a : mag_b)};
              cnt_d    = {CW{1'b0}};
              state_d  = MDU_S_CALC;
            end
            MDU_OP_MTHI: hi_d = iA;
            MDU_OP_MTLO: lo_d = iA;
            default: ;
          endcase
        end else begin
          state_d = MDU_S_IDLE;
        end
      end
      MDU_S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = MDU_S_FIX;
        end else begin
          state_d = MDU_S_CALC;
        end
      end
      MDU_S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (opnd_q == {WIDTH{1'b0}}) begin
          hi_d = a_orig_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        state_d = MDU_S_IDLE;
      end
      default: state_d = MDU_S_IDLE;
    endcase
  end

  // state and register update with synchronous reset
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= MDU_S_IDLE;
      op_q     <= MDU_OP_MULT;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_orig_q <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CW{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_orig_q <= a_orig_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign oBusy = (state_q != MDU_S_IDLE);
  assign oDone = done_q;
  assign oHi   = hi_q;
  assign oLo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops, expected HI/LO queued at issue, checked on oDone.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        iClk, iRst, iStart;
  logic [2:0]  iOp;
  logic [31:0] iA, iB;
  logic        oBusy, oDone;
  logic [31:0] oHi, oLo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oHi(oHi), .oLo(oLo)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // monitor: every oDone pops one expected {HI,LO}
  always @(negedge iClk) begin
    if (oDone === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got oDone=1 expected no pending op (hi=%08h lo=%08h)", oHi, oLo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hi", oHi, e[63:32]);
        chk("result_lo", oLo, e[31:0]);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (oBusy === 1'b1 && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (oBusy === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got oBusy=1 expected 0 within 100 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    wait_idle();
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    if (push) exp_q.push_back({eh, el});
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_at, done_cnt, n;
    iRst = 1'b1; iStart = 1'b0; iOp = 3'd0; iA = 32'd0; iB = 32'd0;
    repeat (2) @(negedge iClk);
    chk("reset_busy", {31'd0, oBusy}, 32'd0);
    chk("reset_done", {31'd0, oDone}, 32'd0);
    chk("reset_hi", oHi, 32'd0);
    chk("reset_lo", oLo, 32'd0);
    iRst = 1'b0;
    @(negedge iClk);

    // latency / handshake
    iStart = 1'b1; iOp = MDU_OP_MULTU; iA = 32'hFFFF_FFFF; iB = 32'hFFFF_FFFF;
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    busy_cnt = 0; done_at = 0; done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge iClk);
      if (c == 1) iStart = 1'b0;
      if (oBusy === 1'b1) busy_cnt++;
      if (oDone === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
        chk("done_cycle_busy", {31'd0, oBusy}, 32'd0);
      end
    end
    chk("busy_cycles", busy_cnt, 32'd33);
    chk("done_edge", done_at, 32'd34);
    chk("done_width", done_cnt, 32'd1);

    issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    issue(MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    issue(MDU_OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b1);
    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
    issue(MDU_OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    issue(MDU_OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b1);

    // MTHI in idle
    wait_idle();
    @(negedge iClk);
    issue(MDU_OP_MTHI, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("mthi_hi", oHi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, oBusy}, 32'd0);
    chk("mthi_done", {31'd0, oDone}, 32'd0);

    // MTLO while busy is ignored
    issue(MDU_OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    repeat (4) @(negedge iClk);
    iStart = 1'b1; iOp = MDU_OP_MTLO; iA = 32'hDEAD_BEEF;
    @(negedge iClk);
    iStart = 1'b0;
    wait_idle();
    @(negedge iClk);
    chk("busy_mtlo_lo", oLo, 32'd15);

    // reset mid-CALC aborts the operation
    issue(MDU_OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    chk("abort_busy", {31'd0, oBusy}, 32'd0);
    chk("abort_done", {31'd0, oDone}, 32'd0);
    chk("abort_hi", oHi, 32'd0);
    chk("abort_lo", oLo, 32'd0);
    iStart = 1'b1; iOp = MDU_OP_DIVU; iA = 32'd100; iB = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    @(negedge iClk);
    iStart = 1'b0;
    chk("post_reset_accept", {31'd0, oBusy}, 32'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
    repeat (5) @(negedge iClk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- It covers the arithmetic the single-cycle ALU does not.
- The control FSM launches an operation with a start pulse and stalls on oBusy.
- MFHI/MFLO read oHi/oLo directly.
- MTHI/MTLO write HI/LO through the same port.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
iClk  input  1  clock, all state updates on rising edge
iRst  input  1  synchronous active-high reset
iStart  input  1  operation request, sampled only in IDLE
iOp  input  3  operation code (MDU_OP_*), sampled with iStart
iA  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
iB  input  WIDTH  rt operand (divisor / multiplier)
oBusy  output  1  high while an iterative operation is in progress
oDone  output  1  one-cycle pulse when HI/LO hold a new mul/div result
oHi  output  WIDTH  HI register
oLo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, iRst=1 at edge):
  - state=IDLE; HI=0, LO=0; oDone=0; oBusy=0.
  - Reset mid-operation aborts the operation with no partial HI/LO write.
  - iRst has priority over iStart.
- States: IDLE, CALC, FIX. oBusy = (state != IDLE), decoded from the state register.
- IDLE, iStart=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch the op and operand signs.
  - Latch |iA| and |iB|; signed ops take the two's-complement magnitude, unsigned ops take the raw value.
  - Clear the counter; go to CALC.
- IDLE, iStart=1, op MTHI/MTLO: HI (resp. LO) <= iA at that edge. Stay IDLE, no oDone, no oBusy.
- IDLE, iStart=1, undefined op: ignored.
- iStart while busy: ignored entirely, including MTHI/MTLO.
- CALC: exactly WIDTH cycles, one iteration per cycle. On the last count, go to FIX.
  - Multiply: radix-2 shift-add on the 2*WIDTH product register.
  - Divide: radix-2 restoring; remainder/quotient pair shifted left, trial subtract of the divisor magnitude.
- FIX: one cycle of sign correction, then write HI/LO and go to IDLE.
  - Signed multiply: 2*WIDTH product negated if operand signs differ. HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, negated if operand signs differ (DIV only). HI = remainder, carrying the dividend's sign (DIV only).
  - Divide by zero (DIV or DIVU): LO = all ones, HI = iA as latched (original signed value). Same latency, no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- oDone: registered. High for exactly the one cycle after FIX, the first cycle in which oHi/oLo show the new result. oBusy is already 0 in that cycle.
- Latency: start sampled at edge k; oBusy high from edge k+1 through edge k+WIDTH+1 (WIDTH+1 cycles); oDone high after edge k+WIDTH+2. For WIDTH=32, a new start is accepted on edge k+34.
- oHi/oLo hold the old values during CALC/FIX.

Decomposition:
- Shared defines.vh:
  - MDU_OP_MULT=3'd0, MDU_OP_MULTU=3'd1, MDU_OP_DIV=3'd2, MDU_OP_DIVU=3'd3, MDU_OP_MTHI=3'd4, MDU_OP_MTLO=3'd5.
  - MDU_CWIDTH=3.
  - State encodings MDU_S_IDLE / MDU_S_CALC / MDU_S_FIX.
- One natural sub-module: mdu_sign_fix. It is combinational and provides conditional two's-complement negation, parameterized width. It is used for the input magnitudes (WIDTH) and the result correction (2*WIDTH / WIDTH).

Test Plan:
- Latency/handshake: MULTU 0xFFFFFFFF*0xFFFFFFFF -> oBusy high 33 cycles, oDone pulse 1 cycle at k+34, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) * 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> LO=0x7FFFFFFC, HI=1.
- Corners:
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
  - DIV 0xFFFFFFF9/0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- MTHI 0x12345678 in IDLE -> oHi=0x12345678 next cycle, oBusy/oDone stay 0.
- Busy start: MTLO 0xDEADBEEF issued during CALC -> ignored; LO ends as the mul/div result.
- Reset: iRst=1 at CALC cycle 10 -> next cycle oBusy=0, oDone=0, HI=LO=0, and no late oDone. A start issued the cycle after reset deasserts is accepted.
